// File: rtl/axi_err_responder.sv
// axi_err_responder: terminating AXI4 subordinate for unmapped address space.
// Accepts every AW/W/AR transaction and completes it with a fixed error
// response. Responses honour ID, burst length and last signalling.
//
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low reset
//   slv_req_i  - AXI request struct from the manager
//   slv_resp_o - AXI response struct to the manager
//   busy_o     - high while any transaction is buffered or in progress

package axi_err_responder_pkg;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned UserWidth = 1;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;
endpackage

// Request FIFO without fall-through; full/empty derive from the registered
// count so a pop never frees a slot for a push in the same cycle.
module axi_err_responder_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] cnt_q;
    logic                do_push, do_pop;

    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CntWidth'(1);
            else if (!do_push && do_pop) cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// state   | meaning
// W_IDLE  | no write in progress, waiting for a buffered AW
// W_DATA  | sinking W beats until w.last
// W_RESP  | presenting the error B response
// R_IDLE  | no read in progress, waiting for a buffered AR
// R_SEND  | streaming len+1 error R beats
module axi_err_responder #(
    parameter logic [1:0]  Resp     = 2'b11,
    parameter logic [63:0] RespData = 64'hCA11_AB1E_BAD_CAB1E,
    parameter int unsigned MaxTrans = 4,
    parameter type aw_chan_t  = axi_err_responder_pkg::aw_chan_t,
    parameter type w_chan_t   = axi_err_responder_pkg::w_chan_t,
    parameter type b_chan_t   = axi_err_responder_pkg::b_chan_t,
    parameter type ar_chan_t  = axi_err_responder_pkg::ar_chan_t,
    parameter type r_chan_t   = axi_err_responder_pkg::r_chan_t,
    parameter type axi_req_t  = axi_err_responder_pkg::axi_req_t,
    parameter type axi_resp_t = axi_err_responder_pkg::axi_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o,
    output logic      busy_o
);
    localparam int unsigned AwIdWidth = $bits(slv_req_i.aw.id);
    localparam int unsigned ArIdWidth = $bits(slv_req_i.ar.id);
    localparam int unsigned LenWidth  = $bits(slv_req_i.ar.len);
    localparam int unsigned DataWidth = $bits(slv_resp_o.r.data);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic       {R_IDLE = 1'b0, R_SEND = 1'b1} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic                          out_en_q;
    logic                          aw_full, aw_empty, aw_push, aw_pop;
    logic [AwIdWidth-1:0]          aw_head_id;
    logic                          ar_full, ar_empty, ar_push, ar_pop;
    logic [ArIdWidth+LenWidth-1:0] ar_head;
    logic [AwIdWidth-1:0]          b_id_q;
    logic [ArIdWidth-1:0]          r_id_q;
    logic [LenWidth-1:0]           r_len_q, beat_cnt_q;
    logic                          w_last_hs, b_hs, r_hs, r_last;
    logic                          unused_req;

    // Most request fields (addresses, sizes, write data) are irrelevant here.
    assign unused_req = ^slv_req_i;

    // Readies stay low while in reset and for the first clock after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) out_en_q <= 1'b0;
        else         out_en_q <= 1'b1;
    end

    assign aw_push   = out_en_q & slv_req_i.aw_valid & ~aw_full;
    assign w_last_hs = (w_state_q == W_DATA) & slv_req_i.w_valid & slv_req_i.w.last;
    assign aw_pop    = w_last_hs;
    assign b_hs      = (w_state_q == W_RESP) & slv_req_i.b_ready;
    assign ar_push   = out_en_q & slv_req_i.ar_valid & ~ar_full;
    assign ar_pop    = (r_state_q == R_IDLE) & ~ar_empty;
    assign r_last    = (beat_cnt_q == r_len_q);
    assign r_hs      = (r_state_q == R_SEND) & slv_req_i.r_ready;

    axi_err_responder_fifo #(.Width(AwIdWidth), .Depth(MaxTrans)) u_aw_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (aw_push),
        .data_i  (slv_req_i.aw.id),
        .pop_i   (aw_pop),
        .data_o  (aw_head_id),
        .full_o  (aw_full),
        .empty_o (aw_empty)
    );

    axi_err_responder_fifo #(.Width(ArIdWidth + LenWidth), .Depth(MaxTrans)) u_ar_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (ar_push),
        .data_i  ({slv_req_i.ar.id, slv_req_i.ar.len}),
        .pop_i   (ar_pop),
        .data_o  (ar_head),
        .full_o  (ar_full),
        .empty_o (ar_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE:  if (!aw_empty) w_state_d = W_DATA;
            W_DATA:  if (w_last_hs) w_state_d = W_RESP;
            // FIFO count already reflects the pop done on w.last.
            W_RESP:  if (b_hs) w_state_d = aw_empty ? W_IDLE : W_DATA;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE:  if (!ar_empty) r_state_d = R_SEND;
            R_SEND:  if (r_hs && r_last) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_id_q     <= '0;
            r_id_q     <= '0;
            r_len_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            if (aw_pop) b_id_q <= aw_head_id;
            if (ar_pop) begin
                r_id_q     <= ar_head[ArIdWidth+LenWidth-1:LenWidth];
                r_len_q    <= ar_head[LenWidth-1:0];
                beat_cnt_q <= '0;
            end else if (r_hs && !r_last) begin
                beat_cnt_q <= beat_cnt_q + LenWidth'(1);
            end
        end
    end

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = out_en_q & ~aw_full;
        slv_resp_o.ar_ready = out_en_q & ~ar_full;
        slv_resp_o.w_ready  = (w_state_q == W_DATA);
        slv_resp_o.b_valid  = (w_state_q == W_RESP);
        slv_resp_o.b.id     = b_id_q;
        slv_resp_o.b.resp   = Resp;
        slv_resp_o.r_valid  = (r_state_q == R_SEND);
        slv_resp_o.r.id     = r_id_q;
        slv_resp_o.r.data   = DataWidth'(RespData);
        slv_resp_o.r.resp   = Resp;
        slv_resp_o.r.last   = (r_state_q == R_SEND) & r_last;
    end

    assign busy_o = ~aw_empty | ~ar_empty | (w_state_q != W_IDLE) | (r_state_q != R_IDLE);
endmodule
